// File: rtl/srt4_div_driver.sv
// srt4_div_driver: valid/ready request/response sequencer for the SRT radix-4 divider core
module srt4_div_driver #(
  parameter int WIDTH   = 8,
  parameter int TIMEOUT = 63
) (
  input  logic             clk,
  input  logic             rst_b,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_dividend,
  input  logic [WIDTH-1:0] req_divisor,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_quotient,
  output logic [WIDTH-1:0] rsp_remainder,
  output logic [1:0]       rsp_status,
  output logic             beginSignal,
  input  logic             endSignal,
  output logic [WIDTH-1:0] core_dividend,
  output logic [WIDTH-1:0] core_divisor,
  input  logic [WIDTH-1:0] core_quotient,
  input  logic [WIDTH-1:0] core_remainder
);
  localparam int WW = $clog2(TIMEOUT + 1);
  localparam logic [1:0] ST_OK = 2'b00, ST_DIV0 = 2'b01, ST_TMO = 2'b10;
  typedef enum logic [1:0] {IDLE, START, BUSY, RESP} state_t;
  state_t state;
  logic [WW-1:0] wd;
  assign req_ready = state == IDLE;
  always_ff @(posedge clk or negedge rst_b)
    if (!rst_b) begin
      state         <= IDLE;
      wd            <= '0;
      beginSignal   <= 1'b0;
      rsp_valid     <= 1'b0;
      rsp_quotient  <= '0;
      rsp_remainder <= '0;
      rsp_status    <= ST_OK;
      core_dividend <= '0;
      core_divisor  <= '0;
    end else
      case (state)
        IDLE:
          if (req_valid) begin
            core_dividend <= req_dividend;
            core_divisor  <= req_divisor;
            if (req_divisor == '0) begin
              rsp_quotient  <= '0;
              rsp_remainder <= '0;
              rsp_status    <= ST_DIV0;
              rsp_valid     <= 1'b1;
              state         <= RESP;
            end else begin
              beginSignal <= 1'b1;
              state       <= START;
            end
          end
        START: begin
          beginSignal <= 1'b0;
          wd          <= '0;
          state       <= BUSY;
        end
        BUSY:
          // completion takes priority over a watchdog expiring the same cycle
          if (endSignal) begin
            rsp_quotient  <= core_quotient;
            rsp_remainder <= core_remainder;
            rsp_status    <= ST_OK;
            rsp_valid     <= 1'b1;
            state         <= RESP;
          end else if (wd == WW'(TIMEOUT - 1)) begin
            rsp_quotient  <= '0;
            rsp_remainder <= '0;
            rsp_status    <= ST_TMO;
            rsp_valid     <= 1'b1;
            state         <= RESP;
          end else
            wd <= wd + WW'(1);
        RESP:
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        default: state <= IDLE;
      endcase
endmodule

// File: tb/tb_srt4_div_driver.sv
// tb_srt4_div_driver: scenario tasks with a response scoreboard for srt4_div_driver
module tb_srt4_div_driver;
  localparam int W = 8;
  localparam int TMO = 63;
  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic [1:0]   st;
  } exp_t;
  logic clk = 0, rst_b = 0;
  logic req_valid = 0, rsp_ready = 0, endSignal = 0;
  logic [W-1:0] req_dividend = 0, req_divisor = 0, core_quotient = 0, core_remainder = 0;
  logic req_ready, rsp_valid, beginSignal;
  logic [W-1:0] rsp_quotient, rsp_remainder, core_dividend, core_divisor;
  logic [1:0] rsp_status;
  exp_t sb[$];
  exp_t e;
  int n_cmp = 0, n_bad = 0, begin_cnt = 0;
  srt4_div_driver #(.WIDTH(W), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst_b(rst_b),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_dividend(req_dividend), .req_divisor(req_divisor),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_quotient(rsp_quotient), .rsp_remainder(rsp_remainder), .rsp_status(rsp_status),
    .beginSignal(beginSignal), .endSignal(endSignal),
    .core_dividend(core_dividend), .core_divisor(core_divisor),
    .core_quotient(core_quotient), .core_remainder(core_remainder)
  );
  always #5 clk = ~clk;
  always @(posedge clk) if (beginSignal) begin_cnt++;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  // drive one request through the accept edge; caller is then in cycle 1
  task automatic issue(input logic [W-1:0] dd, input logic [W-1:0] dv, input logic [W-1:0] q, input logic [W-1:0] r, input logic [1:0] st);
    req_valid = 1;
    req_dividend = dd;
    req_divisor = dv;
    sb.push_back('{q: q, r: r, st: st});
    tick();
    req_valid = 0;
  endtask
  // core model: endSignal is high during cycle end_at (-1 = never); returns the cycle rsp_valid rose
  task automatic wait_rsp(input int end_at, input logic [W-1:0] q, input logic [W-1:0] r, output int cyc);
    cyc = 1;
    while (!rsp_valid && cyc < 200) begin
      endSignal = (cyc == end_at);
      core_quotient = endSignal ? q : 8'hxx;
      core_remainder = endSignal ? r : 8'hxx;
      tick();
      cyc++;
    end
    endSignal = 0;
  endtask
  task automatic handshake();
    rsp_ready = 1;
    tick();
    rsp_ready = 0;
  endtask
  task automatic test_reset();
    tick();
    n_cmp++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL reset_req_ready got %b want 1", req_ready); end
    n_cmp++; if ({rsp_valid, beginSignal, rsp_status} !== 4'b0) begin n_bad++; $display("FAIL reset_ctl got %b want 0000", {rsp_valid, beginSignal, rsp_status}); end
    n_cmp++; if ({core_dividend, core_divisor, rsp_quotient, rsp_remainder} !== 32'b0) begin n_bad++; $display("FAIL reset_data got %h want 0", {core_dividend, core_divisor, rsp_quotient, rsp_remainder}); end
    rst_b = 1;
    tick();
  endtask
  task automatic test_normal();
    int cyc, b0;
    b0 = begin_cnt;
    issue(100, 7, 14, 2, 2'b00);
    n_cmp++; if ({beginSignal, req_ready} !== 2'b10) begin n_bad++; $display("FAIL normal_start got begin/ready %b want 10", {beginSignal, req_ready}); end
    n_cmp++; if ({core_dividend, core_divisor} !== {8'd100, 8'd7}) begin n_bad++; $display("FAIL normal_core_ops got %0d/%0d want 100/7", core_dividend, core_divisor); end
    wait_rsp(21, 14, 2, cyc);
    n_cmp++; if (cyc !== 22) begin n_bad++; $display("FAIL normal_latency got %0d want 22", cyc); end
    e = sb.pop_front();
    n_cmp++; if ({rsp_quotient, rsp_remainder, rsp_status} !== {e.q, e.r, e.st}) begin n_bad++; $display("FAIL normal_rsp got q=%0d r=%0d s=%b want q=%0d r=%0d s=%b", rsp_quotient, rsp_remainder, rsp_status, e.q, e.r, e.st); end
    n_cmp++; if (begin_cnt - b0 !== 1) begin n_bad++; $display("FAIL normal_begin_pulses got %0d want 1", begin_cnt - b0); end
    handshake();
    n_cmp++; if ({rsp_valid, req_ready} !== 2'b01) begin n_bad++; $display("FAIL normal_after_hs got valid/ready %b want 01", {rsp_valid, req_ready}); end
  endtask
  task automatic test_div0();
    int cyc, b0;
    b0 = begin_cnt;
    issue(55, 0, 0, 0, 2'b01);
    wait_rsp(-1, 0, 0, cyc);
    n_cmp++; if (cyc !== 1) begin n_bad++; $display("FAIL div0_latency got %0d want 1", cyc); end
    e = sb.pop_front();
    n_cmp++; if ({rsp_quotient, rsp_remainder, rsp_status} !== {e.q, e.r, e.st}) begin n_bad++; $display("FAIL div0_rsp got q=%0d r=%0d s=%b want q=%0d r=%0d s=%b", rsp_quotient, rsp_remainder, rsp_status, e.q, e.r, e.st); end
    handshake();
    n_cmp++; if (begin_cnt - b0 !== 0) begin n_bad++; $display("FAIL div0_begin_pulses got %0d want 0", begin_cnt - b0); end
    n_cmp++; if ({rsp_valid, req_ready} !== 2'b01) begin n_bad++; $display("FAIL div0_after_hs got valid/ready %b want 01", {rsp_valid, req_ready}); end
  endtask
  task automatic test_timeout();
    int cyc, seen;
    issue(200, 3, 0, 0, 2'b10);
    wait_rsp(-1, 0, 0, cyc);
    n_cmp++; if (cyc !== 2 + TMO) begin n_bad++; $display("FAIL tmo_latency got %0d want %0d", cyc, 2 + TMO); end
    e = sb.pop_front();
    n_cmp++; if ({rsp_quotient, rsp_remainder, rsp_status} !== {e.q, e.r, e.st}) begin n_bad++; $display("FAIL tmo_rsp got q=%0d r=%0d s=%b want q=%0d r=%0d s=%b", rsp_quotient, rsp_remainder, rsp_status, e.q, e.r, e.st); end
    handshake();
    repeat (9) tick();
    endSignal = 1;
    core_quotient = 8'h55;
    core_remainder = 8'h66;
    tick();
    endSignal = 0;
    seen = 0;
    repeat (5) begin
      if (rsp_valid) seen++;
      tick();
    end
    n_cmp++; if (seen !== 0) begin n_bad++; $display("FAIL stray_end got %0d response cycles want 0", seen); end
  endtask
  task automatic test_wd_edge();
    int cyc;
    issue(19, 2, 9, 1, 2'b00);
    wait_rsp(1 + TMO, 9, 1, cyc);
    n_cmp++; if (cyc !== 2 + TMO) begin n_bad++; $display("FAIL wd_edge_latency got %0d want %0d", cyc, 2 + TMO); end
    e = sb.pop_front();
    n_cmp++; if ({rsp_quotient, rsp_remainder, rsp_status} !== {e.q, e.r, e.st}) begin n_bad++; $display("FAIL wd_edge_rsp got q=%0d r=%0d s=%b want q=%0d r=%0d s=%b", rsp_quotient, rsp_remainder, rsp_status, e.q, e.r, e.st); end
    handshake();
  endtask
  task automatic test_back_to_back();
    int cyc, bad;
    issue(30, 5, 6, 0, 2'b00);
    wait_rsp(5, 6, 0, cyc);
    e = sb.pop_front();
    req_valid = 1;
    req_dividend = 77;
    req_divisor = 4;
    sb.push_back('{q: 8'd19, r: 8'd1, st: 2'b00});
    bad = 0;
    repeat (5) begin
      if ({rsp_valid, rsp_quotient, rsp_remainder, rsp_status} !== {1'b1, e.q, e.r, e.st}) bad++;
      if (req_ready !== 1'b0) bad++;
      if ({core_dividend, core_divisor} !== {8'd30, 8'd5}) bad++;
      tick();
    end
    n_cmp++; if (bad !== 0) begin n_bad++; $display("FAIL backpressure_hold got %0d bad samples want 0", bad); end
    rsp_ready = 1;
    tick();
    rsp_ready = 0;
    n_cmp++; if ({rsp_valid, req_ready} !== 2'b01) begin n_bad++; $display("FAIL b2b_idle got valid/ready %b want 01", {rsp_valid, req_ready}); end
    tick();
    req_valid = 0;
    n_cmp++; if ({beginSignal, core_dividend, core_divisor} !== {1'b1, 8'd77, 8'd4}) begin n_bad++; $display("FAIL b2b_accept got begin=%b ops=%0d/%0d want 1 77/4", beginSignal, core_dividend, core_divisor); end
    wait_rsp(3, 19, 1, cyc);
    n_cmp++; if (cyc !== 4) begin n_bad++; $display("FAIL b2b_latency got %0d want 4", cyc); end
    e = sb.pop_front();
    n_cmp++; if ({rsp_quotient, rsp_remainder, rsp_status} !== {e.q, e.r, e.st}) begin n_bad++; $display("FAIL b2b_rsp got q=%0d r=%0d s=%b want q=%0d r=%0d s=%b", rsp_quotient, rsp_remainder, rsp_status, e.q, e.r, e.st); end
    handshake();
  endtask
  task automatic test_reset_busy();
    int cyc;
    issue(12, 3, 4, 0, 2'b00);
    repeat (4) tick();
    #2;
    rst_b = 0;
    #1;
    void'(sb.pop_back());
    n_cmp++; if ({req_ready, rsp_valid, beginSignal} !== 3'b100) begin n_bad++; $display("FAIL rst_busy_ctl got ready/valid/begin %b want 100", {req_ready, rsp_valid, beginSignal}); end
    n_cmp++; if ({core_dividend, core_divisor} !== 16'b0) begin n_bad++; $display("FAIL rst_busy_core got %h want 0", {core_dividend, core_divisor}); end
    tick();
    rst_b = 1;
    tick();
    issue(12, 3, 4, 0, 2'b00);
    wait_rsp(4, 4, 0, cyc);
    n_cmp++; if (cyc !== 5) begin n_bad++; $display("FAIL rst_recover_latency got %0d want 5", cyc); end
    e = sb.pop_front();
    n_cmp++; if ({rsp_quotient, rsp_remainder, rsp_status} !== {e.q, e.r, e.st}) begin n_bad++; $display("FAIL rst_recover_rsp got q=%0d r=%0d s=%b want q=%0d r=%0d s=%b", rsp_quotient, rsp_remainder, rsp_status, e.q, e.r, e.st); end
    handshake();
  endtask
  initial begin
    test_reset();
    test_normal();
    test_div0();
    test_timeout();
    test_wd_edge();
    test_back_to_back();
    test_reset_busy();
    n_cmp++; if (sb.size() !== 0) begin n_bad++; $display("FAIL scoreboard_leftover got %0d want 0", sb.size()); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/srt4_div_driver.md
# srt4_div_driver

Request-side sequencer for the SRT radix-4 divider core. Accepts division requests on a valid/ready port and latches the operands onto the core's operand inputs. It pulses `beginSignal`, waits for `endSignal` under a watchdog, then captures quotient and remainder. The result is held on a valid/ready response port with a status code, so the core sits behind a standard streaming interface.

## Interface
Parameters:
- `WIDTH`, 8: operand, quotient and remainder width.
- `TIMEOUT`, 63: maximum BUSY cycles to wait for `endSignal`. Must be ≥ 1.

Ports:
- `clk` in 1: single clock; all logic on rising edge.
- `rst_b` in 1: asynchronous, active-low reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: driver can accept a request.
- `req_dividend` in WIDTH: dividend.
- `req_divisor` in WIDTH: divisor.
- `rsp_valid` out 1: response present.
- `rsp_ready` in 1: consumer takes response.
- `rsp_quotient` out WIDTH: quotient.
- `rsp_remainder` out WIDTH: remainder.
- `rsp_status` out 2: 00 ok, 01 divide-by-zero, 10 timeout, 11 unused.
- `beginSignal` out 1: one-cycle start pulse to core.
- `endSignal` in 1: core completion.
- `core_dividend` out WIDTH: latched dividend to core.
- `core_divisor` out WIDTH: latched divisor to core.
- `core_quotient` in WIDTH: core quotient, valid while `endSignal`=1.
- `core_remainder` in WIDTH: core remainder, valid while `endSignal`=1.

## Operation
- FSM states: IDLE, START, BUSY, RESP.
- Reset: state IDLE.
  - All registered outputs are 0: `beginSignal`, `core_*`, `rsp_*`, `rsp_status`, and the watchdog.
  - `req_ready` = (state==IDLE), so it reads 1 while in reset.
- IDLE:
  - `req_ready`=1.
  - On `req_valid`: latch `core_dividend`/`core_divisor` from the request.
  - If `req_divisor`==0: load `rsp_quotient`=0, `rsp_remainder`=0, `rsp_status`=01, then go to RESP.
  - Otherwise go to START.
- START:
  - `beginSignal`=1 for exactly this cycle.
  - Watchdog cleared to 0.
  - Go to BUSY.
- BUSY:
  - `beginSignal`=0. `endSignal` is sampled here and only here.
  - On `endSignal`=1: capture `core_quotient`/`core_remainder`, set status 00, go to RESP.
  - Otherwise, if watchdog == TIMEOUT-1: load quotient/remainder 0, status 10, go to RESP.
  - Otherwise increment the watchdog.
  - Watchdog width is clog2(TIMEOUT+1) and it never wraps.
- RESP:
  - `rsp_valid`=1. Data and status hold stable until `rsp_valid && rsp_ready`.
  - On handshake go to IDLE. `rsp_valid` drops the next cycle.
- `core_dividend`/`core_divisor` hold from accept until the next accept, including across RESP and IDLE.
- Boundary rules:
  - `endSignal` in IDLE, START or RESP is ignored; covers a late completion after a timeout.
  - `endSignal` on the same cycle the watchdog expires: completion wins, status 00.
  - `req_valid` while not IDLE: not accepted (`req_ready`=0); the request must stay stable until accepted.
  - Async reset in any state: immediate return to IDLE with reset values, any in-flight result discarded. The core is reset by the same `rst_b`.

## Timing
- Accept at cycle 0 (IDLE, `req_valid`&&`req_ready`).
- `beginSignal` high in cycle 1; BUSY from cycle 2.
- `endSignal` sampled high in cycle k means `rsp_valid` is high from cycle k+1.
- Divide-by-zero: accept at cycle 0, `rsp_valid` at cycle 1, no `beginSignal`.
- Timeout: `rsp_valid` at cycle 2+TIMEOUT when `endSignal` never arrives.
- Minimum request-to-request spacing:
  - Valid division: 4 cycles (IDLE, START, BUSY, RESP) plus core latency.
  - Divide-by-zero: 2 cycles.
- No combinational path from any input to `beginSignal` or `rsp_*`. `req_ready` depends on state only.

## Test plan
- 100/7; core model asserts `endSignal` 20 cycles after `beginSignal` with q=14, r=2 → exactly one `beginSignal` pulse; `rsp_valid` the cycle after `endSignal`; `rsp_quotient`=14, `rsp_remainder`=2, `rsp_status`=00.
- 55/0 → `beginSignal` never asserted; `rsp_valid` at cycle 1 with q=0, r=0, status 01; `req_ready` back to 1 after the handshake.
- 200/3 with the core never ending, TIMEOUT=63 → `rsp_valid` at cycle 65 with status 10, q=r=0. A stray `endSignal` 10 cycles later in IDLE causes no response.
- `endSignal` asserted exactly on the watchdog's last BUSY cycle with q=9, r=1 → status 00, q=9, r=1.
- `rsp_ready` held low 5 cycles in RESP while `req_valid`=1 with new operands → response fields stable, `req_ready`=0, `core_*` unchanged. After the handshake the new request is accepted the next IDLE cycle.
- `rst_b` pulsed low in BUSY → immediately state IDLE, `rsp_valid`=0, `beginSignal`=0, `core_*`=0, `req_ready`=1; the next request completes normally.
